// File: rtl/cic_ctrl_pkg.sv
// Shared types and widths for the CIC decimator sequencer.
package cic_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam int CIC_RW     = 8;
  localparam int OUT_CNT_W  = 32;
  localparam int DROP_CNT_W = 16;
endpackage

// File: rtl/cic_decim_ctrl_if.sv
// Sample/config/enable bundle between the upstream source and the CIC sequencer.
// CIC_CTRL_STATS_EN adds the output and drop counters.
interface cic_decim_ctrl_if
  import cic_ctrl_pkg::*;
#(
  parameter int RW      = CIC_RW,
  parameter int NSTAGES = 3
);
  logic               i_enable;
  logic               i_valid;
  logic               i_cfg_valid;
  logic [RW-1:0]      i_cfg_rate;
  logic               o_cfg_ready;
  logic               o_cfg_err;
  logic               o_int_ce;
  logic [NSTAGES-1:0] o_comb_ce;
  logic               o_valid;
  logic [RW-1:0]      o_phase;
  logic               o_busy;
`ifdef CIC_CTRL_STATS_EN
  logic [OUT_CNT_W-1:0]  o_out_count;
  logic [DROP_CNT_W-1:0] o_drop_count;

  modport master (
    output i_enable, i_valid, i_cfg_valid, i_cfg_rate,
    input  o_cfg_ready, o_cfg_err, o_int_ce, o_comb_ce, o_valid, o_phase, o_busy,
    input  o_out_count, o_drop_count
  );
  modport slave (
    input  i_enable, i_valid, i_cfg_valid, i_cfg_rate,
    output o_cfg_ready, o_cfg_err, o_int_ce, o_comb_ce, o_valid, o_phase, o_busy,
    output o_out_count, o_drop_count
  );
`else
  modport master (
    output i_enable, i_valid, i_cfg_valid, i_cfg_rate,
    input  o_cfg_ready, o_cfg_err, o_int_ce, o_comb_ce, o_valid, o_phase, o_busy
  );
  modport slave (
    input  i_enable, i_valid, i_cfg_valid, i_cfg_rate,
    output o_cfg_ready, o_cfg_err, o_int_ce, o_comb_ce, o_valid, o_phase, o_busy
  );
`endif
endinterface

// File: rtl/cic_ce_pipe.sv
// Comb-enable wavefront: one bit per comb stage plus the final output-valid bit.
module cic_ce_pipe #(
  parameter int NSTAGES = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fire,
  output logic [NSTAGES-1:0] comb_ce,
  output logic               valid,
  output logic               empty
);
  logic [NSTAGES:0] vld_pipe;

  // Plain shift: overlapping wavefronts stay independent single-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[NSTAGES-1:0], fire};
  end

  assign comb_ce = vld_pipe[NSTAGES-1:0];
  assign valid   = vld_pipe[NSTAGES];
  assign empty   = ~|vld_pipe;
endmodule

// File: rtl/cic_decim_ctrl.sv
// CIC decimator sequencer: FSM, phase counter, pending-rate register.
// CIC_CTRL_STATS_EN enables the output/drop statistics counters.
module cic_decim_ctrl
  import cic_ctrl_pkg::*;
#(
  parameter int RW        = CIC_RW,
  parameter int R_DEFAULT = 8,
  parameter int NSTAGES   = 3
) (
  input logic             i_clk,
  input logic             i_reset,
  cic_decim_ctrl_if.slave bus
);
  state_t        state;
  logic [RW-1:0] rate, phase, pend_rate;
  logic          pending, bnd_q, int_ce, cfg_err;
  logic          accept, boundary, xfer, pipe_empty, pipe_valid;

  assign accept   = (state == ST_RUN) && bus.i_valid;
  assign boundary = accept && (phase == rate - RW'(1));
  assign xfer     = bus.i_cfg_valid && !pending;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      rate      <= RW'(R_DEFAULT);
      phase     <= '0;
      pend_rate <= '0;
      pending   <= 1'b0;
      bnd_q     <= 1'b0;
      int_ce    <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      int_ce  <= accept;
      bnd_q   <= boundary;
      cfg_err <= xfer && (bus.i_cfg_rate == '0);

      if (accept) phase <= boundary ? '0 : phase + RW'(1);

      if (xfer && bus.i_cfg_rate != '0) begin
        pending   <= 1'b1;
        pend_rate <= bus.i_cfg_rate;
      end

      // Only a registered pending rate may switch, so an offer landing on a
      // boundary sample waits for the next frame.
      if (pending && (state == ST_IDLE || boundary)) begin
        rate    <= pend_rate;
        pending <= 1'b0;
        phase   <= '0;
      end

      case (state)
        ST_IDLE:  if (bus.i_enable) state <= ST_RUN;
        ST_RUN:   if (!bus.i_enable) state <= ST_FLUSH;
        ST_FLUSH: if (!bnd_q && pipe_empty) begin
          state <= ST_IDLE;
          phase <= '0;
        end
        default:  state <= ST_IDLE;
      endcase
    end
  end

  cic_ce_pipe #(.NSTAGES(NSTAGES)) u_ce_pipe (
    .clk     (i_clk),
    .rst     (i_reset),
    .fire    (bnd_q),
    .comb_ce (bus.o_comb_ce),
    .valid   (pipe_valid),
    .empty   (pipe_empty)
  );

  assign bus.o_valid     = pipe_valid;
  assign bus.o_int_ce    = int_ce;
  assign bus.o_cfg_err   = cfg_err;
  assign bus.o_cfg_ready = !pending;
  assign bus.o_phase     = phase;
  assign bus.o_busy      = (state != ST_IDLE);

`ifdef CIC_CTRL_STATS_EN
  logic [OUT_CNT_W-1:0]  out_cnt;
  logic [DROP_CNT_W-1:0] drop_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      out_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (pipe_valid) out_cnt <= out_cnt + OUT_CNT_W'(1);
      if (bus.i_valid && state != ST_RUN && drop_cnt != '1)
        drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end
  end

  assign bus.o_out_count  = out_cnt;
  assign bus.o_drop_count = drop_cnt;
`endif
endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Directed bench for cic_decim_ctrl (RW=8, R_DEFAULT=8, NSTAGES=3).
module tb_cic_decim_ctrl;
  logic i_clk = 1'b0;
  logic i_reset;
  int   checks = 0;
  int   errors = 0;

  cic_decim_ctrl_if #(.RW(8), .NSTAGES(3)) bus ();

  cic_decim_ctrl #(.RW(8), .R_DEFAULT(8), .NSTAGES(3)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  // Expected traces, index n-1 = observation just after edge n of each phase.
  logic [4:0] t1_ce [12] = '{5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10010, 5'b10100,
                             5'b11000, 5'b10001, 5'b00010, 5'b00100, 5'b01000, 5'b00001};
  logic [7:0] t1_ph [12] = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
  logic [5:0] t5_ce [10] = '{6'b110000, 6'b110000, 6'b110000, 6'b110000, 6'b110010,
                             6'b110100, 6'b101000, 6'b100001, 6'b100000, 6'b000000};
  logic [7:0] t5_ph [10] = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd2, 8'd2, 8'd2, 8'd0};
  logic [5:0] t2_ce [18] = '{6'b010000, 6'b010000, 6'b010000, 6'b110000, 6'b100010, 6'b100100,
                             6'b101000, 6'b100001, 6'b110000, 6'b110010, 6'b110110, 6'b111110,
                             6'b111111, 6'b111111, 6'b101111, 6'b101101, 6'b101001, 6'b100001};
  logic [7:0] t2_ph [18] = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
                             8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
  logic [2:0] t3_ce [16] = '{3'b000, 3'b100, 3'b110, 3'b100, 3'b100, 3'b001, 3'b000, 3'b000,
                             3'b000, 3'b100, 3'b110, 3'b100, 3'b110, 3'b101, 3'b110, 3'b101};
  logic [7:0] t3_ph [16] = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6,
                             8'd7, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_reset         = 1'b1;
    bus.i_enable    = 1'b0;
    bus.i_valid     = 1'b0;
    bus.i_cfg_valid = 1'b0;
    bus.i_cfg_rate  = '0;
    #2;
    check("reset_outputs", 32'({bus.o_cfg_ready, bus.o_cfg_err, bus.o_int_ce, bus.o_comb_ce,
                                bus.o_valid, bus.o_busy, bus.o_phase}), 32'h8000);
    step();
    i_reset = 1'b0;

    // Rate 4 while idle: applied one cycle after acceptance.
    bus.i_cfg_valid = 1'b1;
    bus.i_cfg_rate  = 8'd4;
    step();
    check("idle_cfg_pending", 32'(bus.o_cfg_ready), 32'd0);
    bus.i_cfg_valid = 1'b0;
    step();
    check("idle_cfg_applied", 32'({bus.o_cfg_ready, bus.o_busy}), 32'b10);
    bus.i_enable = 1'b1;
    step();
    check("enter_run", 32'(bus.o_busy), 32'd1);

    // R=4, eight back-to-back samples.
    bus.i_valid = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      step();
      bus.i_valid = (j < 8);
      check($sformatf("r4_stream_%0d", j),
            32'({bus.o_int_ce, bus.o_comb_ce, bus.o_valid, bus.o_phase}),
            32'({t1_ce[j-1], t1_ph[j-1]}));
    end

    // Drop enable at phase 2 with a wavefront in flight.
    bus.i_valid = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      step();
      bus.i_valid  = (n < 6);
      bus.i_enable = (n < 6);
      check($sformatf("flush_%0d", n),
            32'({bus.o_busy, bus.o_int_ce, bus.o_comb_ce, bus.o_valid, bus.o_phase}),
            32'({t5_ce[n-1], t5_ph[n-1]}));
    end
    bus.i_valid = 1'b1;
    step();
    check("idle_ignore_a", 32'({bus.o_int_ce, bus.o_busy, bus.o_phase}), 32'd0);
    step();
    bus.i_valid = 1'b0;
    check("idle_ignore_b", 32'({bus.o_int_ce, bus.o_busy, bus.o_phase}), 32'd0);
`ifdef CIC_CTRL_STATS_EN
    check("drop_count", 32'(bus.o_drop_count), 32'd2);
    check("out_count", bus.o_out_count, 32'd3);
`endif

    // Rate 0 is rejected.
    bus.i_cfg_valid = 1'b1;
    bus.i_cfg_rate  = 8'd0;
    step();
    bus.i_cfg_valid = 1'b0;
    check("cfg_zero_err", 32'({bus.o_cfg_err, bus.o_cfg_ready}), 32'b11);
    step();
    check("cfg_zero_clear", 32'({bus.o_cfg_err, bus.o_cfg_ready}), 32'b01);

    // Rate still 4; rate 1 offered with the first sample lands on the boundary.
    bus.i_enable = 1'b1;
    step();
    check("rerun", 32'(bus.o_busy), 32'd1);
    bus.i_valid     = 1'b1;
    bus.i_cfg_valid = 1'b1;
    bus.i_cfg_rate  = 8'd1;
    for (int n = 1; n <= 18; n++) begin
      step();
      bus.i_cfg_valid = 1'b0;
      bus.i_valid     = (n <= 3) || (n >= 8 && n <= 13);
      check($sformatf("r1_stream_%0d", n),
            32'({bus.o_cfg_ready, bus.o_int_ce, bus.o_comb_ce, bus.o_valid, bus.o_phase}),
            32'({t2_ce[n-1], t2_ph[n-1]}));
    end

    // Back to 8, then offer 2 at phase 3: old frame finishes first.
    bus.i_cfg_valid = 1'b1;
    bus.i_cfg_rate  = 8'd8;
    bus.i_valid     = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      step();
      bus.i_cfg_valid = (n + 1 == 6);
      bus.i_cfg_rate  = (n + 1 == 6) ? 8'd2 : 8'd8;
      bus.i_valid     = (n + 1 >= 2) && (n + 1 <= 14);
      check($sformatf("rate_change_%0d", n),
            32'({bus.o_cfg_ready, bus.o_comb_ce[0], bus.o_valid, bus.o_phase}),
            32'({t3_ce[n-1], t3_ph[n-1]}));
    end

    // Reset mid-wavefront.
    bus.i_valid = 1'b1;
    step();
    step();
    step();
    bus.i_valid = 1'b0;
    check("pre_reset", 32'({bus.o_comb_ce, bus.o_valid, bus.o_phase}), 32'({3'b001, 1'b0, 8'd1}));
    #2;
    i_reset = 1'b1;
    #1;
    check("async_reset", 32'({bus.o_cfg_ready, bus.o_cfg_err, bus.o_int_ce, bus.o_comb_ce,
                              bus.o_valid, bus.o_busy, bus.o_phase}), 32'h8000);
`ifdef CIC_CTRL_STATS_EN
    check("stats_reset", 32'({bus.o_out_count[15:0], bus.o_drop_count}), 32'd0);
`endif
    #2;
    i_reset = 1'b0;
    step();
    check("rerun_after_reset", 32'(bus.o_busy), 32'd1);
    bus.i_valid = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      step();
      check($sformatf("default_rate_%0d", n), 32'(bus.o_phase), 32'(n % 8));
    end
    bus.i_valid = 1'b0;
    step();
    check("default_rate_comb", 32'(bus.o_comb_ce), 32'b001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
